// File: rtl/des_sched_pkg.sv
// Shared types for the DES core scheduler: slot and top-level state encodings.
package des_sched_pkg;
  typedef enum logic [1:0] {S_FREE, S_RUNNING, S_RESTART} slot_state_e;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_e;
  // The core LFSR locks up on an all-zero seed, so zero is swapped for this.
  localparam logic [63:0] ZERO_SEED_SUB = 64'h1;
endpackage

// File: rtl/des_core_scheduler_slot.sv
// One core's slot: FREE/RUNNING/RESTART tracking, seed hold and start/restart pulses.
module core_slot
  import des_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dispatch,
  input  logic        collect,
  input  logic [63:0] seed_in,
  output logic        free,
  output logic        running,
  output logic        busy,
  output logic        start_pulse,
  output logic        restart_pulse,
  output logic [63:0] seed
);
  slot_state_e state;

  assign free    = (state == S_FREE);
  assign running = (state == S_RUNNING);
  assign busy    = (state != S_FREE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FREE;
      start_pulse   <= 1'b0;
      restart_pulse <= 1'b0;
      seed          <= '0;
    end else begin
      start_pulse   <= 1'b0;
      restart_pulse <= 1'b0;
      case (state)
        S_FREE: if (dispatch) begin
          state       <= S_RUNNING;
          seed        <= seed_in;
          start_pulse <= 1'b1;
        end
        S_RUNNING: if (collect) begin
          state         <= S_RESTART;
          restart_pulse <= 1'b1;
        end
        default: state <= S_FREE;
      endcase
    end
  end
endmodule

// File: rtl/des_core_scheduler.sv
// Splits a run of jobs across the DES cores and accumulates their match counters.
module des_core_scheduler
  import des_sched_pkg::*;
#(
  parameter int NUM_CORES = 6,
  parameter int ACC_W     = 72,
  parameter int JOB_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [JOB_W-1:0]        job_count,
  input  logic [63:0]             seed_base,
  input  logic [63:0]             seed_step,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*64-1:0] core_counter,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES-1:0]    core_restart,
  output logic [NUM_CORES*64-1:0] core_seed,
  output logic                    busy,
  output logic                    done,
  output logic [JOB_W-1:0]        jobs_completed,
  output logic [ACC_W-1:0]        total_count
);
  localparam logic [JOB_W-1:0] JOB_ONE = 1;

  top_state_e           state;
  logic [JOB_W-1:0]     job_total, job_idx;
  logic [63:0]          seed_acc, step_r, next_seed, coll_counter;
  logic [NUM_CORES-1:0] slot_free, slot_running, slot_busy;
  logic [NUM_CORES-1:0] dispatch, collect;
  logic                 can_dispatch;

  assign busy         = (state == T_RUN);
  assign done         = (state == T_DONE);
  assign can_dispatch = (state == T_RUN) && (job_idx < job_total);
  assign next_seed    = (seed_acc == 64'd0) ? ZERO_SEED_SUB : seed_acc;

  // Lowest-index priority: iterate downward so the lowest match is written last.
  always_comb begin
    dispatch     = '0;
    collect      = '0;
    coll_counter = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (slot_free[k]) begin
        dispatch    = '0;
        dispatch[k] = can_dispatch;
      end
      if (slot_running[k] && core_done[k]) begin
        collect      = '0;
        collect[k]   = 1'b1;
        coll_counter = core_counter[64*k +: 64];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= T_IDLE;
      job_total      <= '0;
      job_idx        <= '0;
      seed_acc       <= '0;
      step_r         <= '0;
      jobs_completed <= '0;
      total_count    <= '0;
    end else begin
      case (state)
        T_RUN: begin
          if (|dispatch) begin
            job_idx  <= job_idx + JOB_ONE;
            seed_acc <= seed_acc + step_r;
          end
          if (|collect) begin
            total_count    <= total_count + {{(ACC_W-64){1'b0}}, coll_counter};
            jobs_completed <= jobs_completed + JOB_ONE;
          end
          if (jobs_completed == job_total && !(|slot_busy))
            state <= T_DONE;
        end
        default: if (start) begin
          state          <= T_RUN;
          job_total      <= job_count;
          seed_acc       <= seed_base;
          step_r         <= seed_step;
          job_idx        <= '0;
          jobs_completed <= '0;
          total_count    <= '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
    core_slot u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .dispatch      (dispatch[k]),
      .collect       (collect[k]),
      .seed_in       (next_seed),
      .free          (slot_free[k]),
      .running       (slot_running[k]),
      .busy          (slot_busy[k]),
      .start_pulse   (core_start[k]),
      .restart_pulse (core_restart[k]),
      .seed          (core_seed[64*k +: 64])
    );
  end
endmodule

// File: tb/tb_des_core_scheduler.sv
// Directed bench for des_core_scheduler with stub cores (done after lat[k] cycles, counter = seed[15:0]).
module tb_des_core_scheduler;
  localparam int NC = 6;
  localparam int ACC_W = 72;
  localparam int JOB_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [JOB_W-1:0]  job_count = '0;
  logic [63:0]       seed_base = '0, seed_step = '0;
  logic [NC-1:0]     core_done, core_start, core_restart;
  logic [NC*64-1:0]  core_counter, core_seed;
  logic              busy, done;
  logic [JOB_W-1:0]  jobs_completed;
  logic [ACC_W-1:0]  total_count;

  des_core_scheduler #(.NUM_CORES(NC), .ACC_W(ACC_W), .JOB_W(JOB_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_count(job_count),
    .seed_base(seed_base), .seed_step(seed_step), .core_done(core_done),
    .core_counter(core_counter), .core_start(core_start), .core_restart(core_restart),
    .core_seed(core_seed), .busy(busy), .done(done),
    .jobs_completed(jobs_completed), .total_count(total_count)
  );

  always #5 clk = ~clk;

  // stub cores
  int            lat [NC];
  int            cnt [NC];
  logic [NC-1:0] act, sd_done;
  logic [63:0]   sd  [NC];

  assign core_done = sd_done;
  always_comb begin
    core_counter = '0;
    for (int k = 0; k < NC; k++) core_counter[64*k +: 64] = {48'd0, sd[k][15:0]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= '0;
      sd_done <= '0;
      for (int k = 0; k < NC; k++) begin cnt[k] <= 0; sd[k] <= '0; end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          cnt[k] <= lat[k];
          act[k] <= 1'b1;
          sd[k]  <= core_seed[64*k +: 64];
        end else if (act[k]) begin
          if (cnt[k] <= 1) begin sd_done[k] <= 1'b1; act[k] <= 1'b0; end
          else cnt[k] <= cnt[k] - 1;
        end
        if (core_restart[k]) sd_done[k] <= 1'b0;
      end
    end
  end

  // pulse monitor
  int          cyc = 0;
  int          n_starts;
  int          start_cnt [NC];
  int          first_start [NC];
  logic [63:0] first_seed [NC];
  int          last_rst [NC];
  int          min_gap;
  logic [63:0] seed0_q [$];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NC; k++) begin
      if (core_start[k]) begin
        n_starts++;
        if (start_cnt[k] == 0) begin
          first_start[k] = cyc;
          first_seed[k]  = core_seed[64*k +: 64];
        end
        start_cnt[k]++;
        if (k == 0) seed0_q.push_back(core_seed[63:0]);
        if (last_rst[k] >= 0 && cyc - last_rst[k] < min_gap) min_gap = cyc - last_rst[k];
      end
      if (core_restart[k]) last_rst[k] = cyc;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    n_starts = 0;
    min_gap = 1000;
    seed0_q.delete();
    for (int k = 0; k < NC; k++) begin
      start_cnt[k] = 0; first_start[k] = 0; first_seed[k] = '0; last_rst[k] = -1;
    end
  endtask

  task automatic set_lat(input int l);
    for (int k = 0; k < NC; k++) lat[k] = l;
  endtask

  task automatic run(input logic [31:0] jc, input logic [63:0] base, input logic [63:0] step);
    @(negedge clk);
    mon_clear();
    job_count = jc; seed_base = base; seed_step = step; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_reached", done, 1'b1);
  endtask

  initial begin
    set_lat(10);
    mon_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_total", total_count, '0);
    chk("rst_jobs", jobs_completed, '0);
    chk("rst_pulses", {core_start, core_restart}, '0);
    chk("rst_seed", core_seed, '0);
    rst_n = 1'b1;

    // six jobs, one per core
    run(6, 64'd1, 64'd1);
    chk("a_busy", busy, 1'b1);
    wait_done(300);
    chk("a_total", total_count, 21);
    chk("a_jobs", jobs_completed, 6);
    chk("a_busy_end", busy, 1'b0);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("a_starts%0d", k), start_cnt[k], 1);
      chk($sformatf("a_cyc%0d", k), first_start[k] - first_start[0], k);
      chk($sformatf("a_seed%0d", k), first_seed[k], k + 1);
    end

    // thirteen jobs: core 0 wraps around twice
    run(13, 64'd1, 64'd1);
    wait_done(600);
    chk("b_total", total_count, 91);
    chk("b_jobs", jobs_completed, 13);
    chk("b_core0_starts", start_cnt[0], 3);
    chk("b_core0_seed0", seed0_q.size() > 0 ? seed0_q[0] : 64'hdead, 1);
    chk("b_core0_seed1", seed0_q.size() > 1 ? seed0_q[1] : 64'hdead, 7);
    chk("b_core0_seed2", seed0_q.size() > 2 ? seed0_q[2] : 64'hdead, 13);
    chk("b_turnaround", min_gap >= 2, 1'b1);

    // zero jobs
    run(0, 64'd5, 64'd5);
    chk("z_done_early", done, 1'b0);
    @(negedge clk);
    chk("z_done", done, 1'b1);
    chk("z_starts", n_starts, 0);
    chk("z_total", total_count, 0);

    // cores 2 and 4 finish on the same cycle
    lat[0] = 5; lat[1] = 5; lat[2] = 20; lat[3] = 5; lat[4] = 18; lat[5] = 5;
    run(6, 64'd100, 64'd1);
    wait_done(300);
    chk("c_order", last_rst[4] - last_rst[2], 1);
    chk("c_total", total_count, 615);

    // seed wrap to zero is replaced by 1
    set_lat(10);
    run(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(300);
    chk("w_seed0", first_seed[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w_seed1", first_seed[1], 64'h1);
    chk("w_core2_idle", start_cnt[2], 0);
    chk("w_total", total_count, 64'h10000);

    // reset with three cores running
    set_lat(50);
    run(6, 64'd1, 64'd1);
    for (int i = 0; i < 20 && n_starts < 3; i++) @(negedge clk);
    chk("r_three_started", n_starts >= 3, 1'b1);
    chk("r_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 1'b0);
    chk("r_seed", core_seed, '0);
    chk("r_pulses", {core_start, core_restart}, '0);
    chk("r_jobs", jobs_completed, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_lat(10);
    run(6, 64'd1, 64'd1);
    wait_done(300);
    chk("r_total", total_count, 21);
    chk("r_jobs_end", jobs_completed, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
